// File: rtl/ebox_pkg.sv
// Shared EBOX types and constants for the store queue and its forwarding search.
package ebox_pkg;

  localparam int unsigned STOREQ_DEPTH_DEFAULT = 4;
  // Entry address field is sized for the widest supported PA; narrower PAs are zero-extended.
  localparam int unsigned STOREQ_PA_W_MAX = 32;

  // PDP-10 bit n of a word lives at vector index 35-n, so LH is [35:18] and RH is [17:0].
  // we[1] enables LH, we[0] enables RH.
  typedef struct packed {
    logic [35:0]                data;
    logic [STOREQ_PA_W_MAX-1:0] pa;
    logic [1:0]                 we;
  } tStoreEntry;

  typedef enum logic {sqIDLE, sqREQ} tStoreQState;

endpackage

// File: rtl/store_fwd_match.sv
// Combinational store-to-load forwarding: youngest valid entry matching READ_PA wins,
// searched independently per halfword.
module store_fwd_match
  import ebox_pkg::*;
#(
  parameter int unsigned DEPTH = STOREQ_DEPTH_DEFAULT,
  parameter int unsigned PA_W  = 22
) (
  input  tStoreEntry               entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [PA_W-1:0]          read_pa,
  output logic [1:0]               fwd_hit,
  output logic [35:0]              fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    idx      = '0;
    // Walk from the head (oldest) toward the tail so later matches override earlier ones.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].pa == STOREQ_PA_W_MAX'(read_pa))) begin
        if (entries[idx].we[1]) begin
          fwd_hit[1]       = 1'b1;
          fwd_data[35:18]  = entries[idx].data[35:18];
        end
        if (entries[idx].we[0]) begin
          fwd_hit[0]       = 1'b1;
          fwd_data[17:0]   = entries[idx].data[17:0];
        end
      end
    end
  end

endmodule

// File: rtl/ebox_store_queue.sv
// In-order store FIFO between the EBOX data path and the MBOX cache write port,
// with odd parity on the drain side and same-address forwarding to EBOX reads.
module ebox_store_queue
  import ebox_pkg::*;
#(
  parameter int unsigned DEPTH = STOREQ_DEPTH_DEFAULT,
  parameter int unsigned PA_W  = 22
) (
  input  logic                   CLK_EDP,
  input  logic                   FPGA_RESET_N,
  input  logic                   STORE_REQ,
  input  logic [35:0]            STORE_DATA,
  input  logic [PA_W-1:0]        STORE_PA,
  input  logic [1:0]             STORE_WE,
  output logic                   STORE_FULL,
  input  logic                   FLUSH,
  output logic                   MB_REQ,
  input  logic                   MB_ACK,
  output logic [35:0]            MB_DATA,
  output logic                   MB_PAR,
  output logic [PA_W-1:0]        MB_PA,
  output logic [1:0]             MB_WE,
  input  logic [PA_W-1:0]        READ_PA,
  output logic [1:0]             FWD_HIT,
  output logic [35:0]            FWD_DATA,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   STORE_OVF
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tStoreEntry       mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  tStoreQState      state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             full, push, pop;

  assign full = (count_q == CNT_W'(DEPTH));
  // A push while full is dropped even if the head pops on the same edge.
  assign push = STORE_REQ & ~full & ~FLUSH;
  assign pop  = (state_q == sqREQ) & MB_ACK;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q;
    state_d = state_q;
    ovf_d   = ovf_q;
    if (FLUSH) begin
      head_d  = tail_q;
      valid_d = '0;
      count_d = '0;
      state_d = sqIDLE;
      ovf_d   = 1'b0;
    end else begin
      if (STORE_REQ && full) ovf_d = 1'b1;
      if (push) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        sqIDLE:  if (push) state_d = sqREQ;
        sqREQ:   if (pop && !push && (count_q == CNT_W'(1))) state_d = sqIDLE;
        default: state_d = sqIDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_EDP or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
      state_q <= sqIDLE;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge CLK_EDP) begin
    if (push) begin
      mem_q[tail_q] <= '{data: STORE_DATA, pa: STOREQ_PA_W_MAX'(STORE_PA), we: STORE_WE};
    end
  end

  assign MB_REQ     = (state_q == sqREQ);
  assign MB_DATA    = MB_REQ ? mem_q[head_q].data : '0;
  assign MB_PA      = MB_REQ ? mem_q[head_q].pa[PA_W-1:0] : '0;
  assign MB_WE      = MB_REQ ? mem_q[head_q].we : '0;
  assign MB_PAR     = ~^MB_DATA;
  assign STORE_FULL = full;
  assign COUNT      = count_q;
  assign STORE_OVF  = ovf_q;

  store_fwd_match #(
    .DEPTH (DEPTH),
    .PA_W  (PA_W)
  ) u_fwd (
    .entries  (mem_q),
    .valid    (valid_q),
    .head     (head_q),
    .read_pa  (READ_PA),
    .fwd_hit  (FWD_HIT),
    .fwd_data (FWD_DATA)
  );

endmodule

// File: tb/tb_ebox_store_queue.sv
// Directed bench for ebox_store_queue: queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_ebox_store_queue;

  localparam int DEPTH = 4;
  localparam int PA_W  = 22;

  logic              CLK_EDP = 1'b0;
  logic              FPGA_RESET_N = 1'b0;
  logic              STORE_REQ = 1'b0;
  logic [35:0]       STORE_DATA = '0;
  logic [PA_W-1:0]   STORE_PA = '0;
  logic [1:0]        STORE_WE = '0;
  logic              STORE_FULL;
  logic              FLUSH = 1'b0;
  logic              MB_REQ;
  logic              MB_ACK = 1'b0;
  logic [35:0]       MB_DATA;
  logic              MB_PAR;
  logic [PA_W-1:0]   MB_PA;
  logic [1:0]        MB_WE;
  logic [PA_W-1:0]   READ_PA = '0;
  logic [1:0]        FWD_HIT;
  logic [35:0]       FWD_DATA;
  logic [2:0]        COUNT;
  logic              STORE_OVF;

  ebox_store_queue #(
    .DEPTH (DEPTH),
    .PA_W  (PA_W)
  ) dut (
    .CLK_EDP      (CLK_EDP),
    .FPGA_RESET_N (FPGA_RESET_N),
    .STORE_REQ    (STORE_REQ),
    .STORE_DATA   (STORE_DATA),
    .STORE_PA     (STORE_PA),
    .STORE_WE     (STORE_WE),
    .STORE_FULL   (STORE_FULL),
    .FLUSH        (FLUSH),
    .MB_REQ       (MB_REQ),
    .MB_ACK       (MB_ACK),
    .MB_DATA      (MB_DATA),
    .MB_PAR       (MB_PAR),
    .MB_PA        (MB_PA),
    .MB_WE        (MB_WE),
    .READ_PA      (READ_PA),
    .FWD_HIT      (FWD_HIT),
    .FWD_DATA     (FWD_DATA),
    .COUNT        (COUNT),
    .STORE_OVF    (STORE_OVF)
  );

  always #5 CLK_EDP = ~CLK_EDP;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the queue contents, oldest first.
  typedef struct {
    logic [35:0]     d;
    logic [PA_W-1:0] pa;
    logic [1:0]      we;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf = 1'b0;
  int   m_xfers = 0;
  int   dut_xfers = 0;

  always @(posedge CLK_EDP or negedge FPGA_RESET_N) begin : model
    bit was_full;
    bit popv;
    if (!FPGA_RESET_N) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      popv     = (m_q.size() != 0) && MB_ACK;
      if (MB_REQ && MB_ACK) dut_xfers++;
      if (popv) m_xfers++;
      if (FLUSH) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (popv) void'(m_q.pop_front());
        if (STORE_REQ) begin
          if (was_full) m_ovf = 1'b1;
          else m_q.push_back('{STORE_DATA, STORE_PA, STORE_WE});
        end
      end
    end
  end

  task automatic model_fwd(input logic [PA_W-1:0] rpa, output logic [1:0] h,
                           output logic [35:0] d);
    h = '0;
    d = '0;
    foreach (m_q[i]) begin
      if (m_q[i].pa == rpa) begin
        if (m_q[i].we[1]) begin h[1] = 1'b1; d[35:18] = m_q[i].d[35:18]; end
        if (m_q[i].we[0]) begin h[0] = 1'b1; d[17:0]  = m_q[i].d[17:0];  end
      end
    end
  endtask

  always @(negedge CLK_EDP) begin : compare
    logic [35:0]     e_d;
    logic [PA_W-1:0] e_pa;
    logic [1:0]      e_we;
    logic [1:0]      e_h;
    logic [35:0]     e_fd;
    if (cmp_en) begin
      e_d  = '0;
      e_pa = '0;
      e_we = '0;
      if (m_q.size() != 0) begin
        e_d  = m_q[0].d;
        e_pa = m_q[0].pa;
        e_we = m_q[0].we;
      end
      model_fwd(READ_PA, e_h, e_fd);
      chk("count", 64'(COUNT), 64'(m_q.size()));
      chk("store_full", 64'(STORE_FULL), 64'(m_q.size() == DEPTH));
      chk("store_ovf", 64'(STORE_OVF), 64'(m_ovf));
      chk("mb_req", 64'(MB_REQ), 64'(m_q.size() != 0));
      chk("mb_data", 64'(MB_DATA), 64'(e_d));
      chk("mb_pa", 64'(MB_PA), 64'(e_pa));
      chk("mb_we", 64'(MB_WE), 64'(e_we));
      chk("mb_par", 64'(MB_PAR), 64'(~^e_d));
      chk("fwd_hit", 64'(FWD_HIT), 64'(e_h));
      chk("fwd_data", 64'(FWD_DATA), 64'(e_fd));
    end
  end

  // Apply inputs for one edge, then return 2 time units after it with strobes cleared.
  task automatic cyc(input logic req, input logic [35:0] d, input logic [PA_W-1:0] pa,
                     input logic [1:0] we, input logic ack, input logic fl);
    STORE_REQ  = req;
    STORE_DATA = d;
    STORE_PA   = pa;
    STORE_WE   = we;
    MB_ACK     = ack;
    FLUSH      = fl;
    @(posedge CLK_EDP);
    #2;
    STORE_REQ = 1'b0;
    MB_ACK    = 1'b0;
    FLUSH     = 1'b0;
  endtask

  task automatic push(input logic [35:0] d, input logic [PA_W-1:0] pa, input logic [1:0] we);
    cyc(1'b1, d, pa, we, 1'b0, 1'b0);
  endtask

  task automatic ack1();
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    #3;
    chk("rst_mb_req", 64'(MB_REQ), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_full", 64'(STORE_FULL), 64'd0);
    chk("rst_ovf", 64'(STORE_OVF), 64'd0);
    chk("rst_mb_data", 64'(MB_DATA), 64'd0);
    chk("rst_mb_par", 64'(MB_PAR), 64'd1);
    chk("rst_fwd_hit", 64'(FWD_HIT), 64'd0);
    #9 FPGA_RESET_N = 1'b1;
    @(posedge CLK_EDP);
    #2;
    cmp_en = 1'b1;

    // 1: single push, hold, ack
    push(36'o123456654321, 22'h000100, 2'b11);
    chk("t1_req", 64'(MB_REQ), 64'd1);
    chk("t1_data", 64'(MB_DATA), 64'(36'o123456654321));
    chk("t1_par", 64'(MB_PAR), 64'd1);
    chk("t1_count", 64'(COUNT), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("t1_hold", 64'(MB_DATA), 64'(36'o123456654321));
    ack1();
    chk("t1_req_off", 64'(MB_REQ), 64'd0);
    chk("t1_count0", 64'(COUNT), 64'd0);

    // 2: fill, overflow, drain back-to-back; second burst wraps the pointers
    for (int i = 0; i < 4; i++) push(36'o100000000000 + 36'(i), PA_W'(22'h200 + i), 2'b11);
    chk("t2_full", 64'(STORE_FULL), 64'd1);
    push(36'o777777777777, 22'h2FF, 2'b11);
    chk("t2_count", 64'(COUNT), 64'd4);
    chk("t2_ovf", 64'(STORE_OVF), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(MB_DATA), 64'(36'o100000000000 + 36'(i)));
      ack1();
    end
    chk("t2_empty", 64'(MB_REQ), 64'd0);
    for (int i = 0; i < 4; i++) push(36'o200000000000 + 36'(i), PA_W'(22'h240 + i), 2'b10);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order2", 64'(MB_DATA), 64'(36'o200000000000 + 36'(i)));
      ack1();
    end

    // 3: push+ack while full, then push+ack at occupancy 2
    for (int i = 0; i < 4; i++) push(36'o300000000000 + 36'(i), PA_W'(22'h280 + i), 2'b01);
    cyc(1'b1, 36'o377777777777, 22'h2FE, 2'b11, 1'b1, 1'b0);
    chk("t3_count3", 64'(COUNT), 64'd3);
    chk("t3_ovf", 64'(STORE_OVF), 64'd1);
    ack1();
    cyc(1'b1, 36'o355555555555, 22'h2FD, 2'b11, 1'b1, 1'b0);
    chk("t3_count2", 64'(COUNT), 64'd2);
    chk("t3_head", 64'(MB_DATA), 64'(36'o300000000003));
    ack1();
    ack1();

    // 4: forwarding merge, youngest per halfword
    push({18'o777777, 18'o555555}, 22'h5, 2'b10);
    push({18'o222222, 18'o000001}, 22'h5, 2'b01);
    push({18'o111111, 18'o333333}, 22'h5, 2'b10);
    READ_PA = 22'h5;
    #1;
    chk("t4_hit", 64'(FWD_HIT), 64'(2'b11));
    chk("t4_data", 64'(FWD_DATA), 64'(36'o111111000001));
    READ_PA = 22'h6;
    #1;
    chk("t4_miss_hit", 64'(FWD_HIT), 64'd0);
    chk("t4_miss_data", 64'(FWD_DATA), 64'd0);

    // 5: flush with concurrent ack and push
    READ_PA = 22'h5;
    chk("t5_head", 64'(MB_DATA), 64'({18'o777777, 18'o555555}));
    cyc(1'b1, 36'o444444444444, 22'h5, 2'b11, 1'b1, 1'b1);
    chk("t5_count", 64'(COUNT), 64'd0);
    chk("t5_req", 64'(MB_REQ), 64'd0);
    chk("t5_ovf", 64'(STORE_OVF), 64'd0);
    chk("t5_fwd", 64'(FWD_HIT), 64'd0);
    chk("t5_xfers", 64'(dut_xfers), 64'd15);

    // 6: async reset mid-REQ, then a fresh queue
    for (int i = 0; i < 4; i++) push(36'o500000000000 + 36'(i), PA_W'(22'h300 + i), 2'b11);
    chk("t6_full", 64'(STORE_FULL), 64'd1);
    #1 FPGA_RESET_N = 1'b0;
    #1;
    chk("t6_req", 64'(MB_REQ), 64'd0);
    chk("t6_count", 64'(COUNT), 64'd0);
    chk("t6_full0", 64'(STORE_FULL), 64'd0);
    chk("t6_data", 64'(MB_DATA), 64'd0);
    #3 FPGA_RESET_N = 1'b1;
    push(36'o765432101234, 22'h3FF, 2'b01);
    chk("t6_count1", 64'(COUNT), 64'd1);
    chk("t6_head", 64'(MB_DATA), 64'(36'o765432101234));
    READ_PA = 22'h3FF;
    #1;
    chk("t6_fwd_hit", 64'(FWD_HIT), 64'(2'b01));
    chk("t6_fwd_data", 64'(FWD_DATA), 64'(36'o000000101234));
    ack1();
    chk("t6_done", 64'(COUNT), 64'd0);
    chk("xfers_total", 64'(dut_xfers), 64'd16);
    chk("xfers_model", 64'(dut_xfers), 64'(m_xfers));

    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
